// File: rtl/regfile_seq_pkg.sv
// Shared definitions for the register-file sequencer.
//   - DEF_DW / DEF_AW / DEF_SCRATCH : default data width, address width and
//     scratch register used as the write target during operand fetch
//   - OP_* : command opcodes (10-15 are unassigned and execute as MOV)
//   - state_t : sequencer FSM states
package regfile_seq_pkg;

  localparam int DEF_DW      = 16;
  localparam int DEF_AW      = 4;
  localparam int DEF_SCRATCH = 15;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;
  localparam logic [3:0] OP_LDI = 4'd8;
  localparam logic [3:0] OP_CLR = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_CLR   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/seq_alu.sv
// Combinational ALU for the register-file sequencer.
//   op : opcode (OP_ADD..OP_SHR, everything else passes a through)
//   a  : operand A (rs1)
//   b  : operand B (rs2); only b[3:0] is used as shift amount
//   y  : result, W bits, arithmetic wraps with no flags
module seq_alu
  import regfile_seq_pkg::*;
#(
  parameter int W = DEF_DW
) (
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  logic [3:0] shamt;
  assign shamt = b[3:0];

  always_comb begin
    y = a;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SHL:  y = a << shamt;
      OP_SHR:  y = a >> shamt;
      default: y = a;   // MOV and the unassigned opcodes
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Command sequencer in front of a 2-read/1-write register file.
// Takes one command at a time (valid/ready), fetches operands through the
// regfile's Load edge, runs seq_alu, writes the result back and holds a
// response until it is accepted.
// Ports:
//   Clk, Clear                      clock, async active-high block reset
//   cmd_valid/cmd_ready             command handshake (ready only in IDLE)
//   cmd_op/rd/rs1/rs2/imm           command fields
//   rf_aaddr/baddr/caddr/c          regfile addresses and write data
//   rf_load, rf_clear_n             regfile Load (high) and Clear (low)
//   rf_a, rf_b                      regfile read data, valid after a Load edge
//   resp_valid/resp_ready           response handshake
//   resp_result, resp_rd            written value and destination
module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int            DW           = DEF_DW,
  parameter int            AW           = DEF_AW,
  parameter logic [AW-1:0] SCRATCH_ADDR = AW'(DEF_SCRATCH)
) (
  input  logic          Clk,
  input  logic          Clear,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic [DW-1:0] cmd_imm,
  output logic [AW-1:0] rf_aaddr,
  output logic [AW-1:0] rf_baddr,
  output logic [AW-1:0] rf_caddr,
  output logic [DW-1:0] rf_c,
  output logic          rf_load,
  output logic          rf_clear_n,
  input  logic [DW-1:0] rf_a,
  input  logic [DW-1:0] rf_b,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_result,
  output logic [AW-1:0] resp_rd
);

  state_t        state, state_nx;
  logic [3:0]    op_q;
  logic [AW-1:0] rd_q, rs1_q, rs2_q;
  logic [DW-1:0] res_q;
  logic [DW-1:0] alu_y;
  logic          accept;

  // Derived from state directly (not from cmd_ready) so the next-state
  // logic below has no loop back through its own outputs.
  assign accept = cmd_valid && (state == S_IDLE);

  seq_alu #(.W(DW)) u_alu (
    .op (op_q),
    .a  (rf_a),
    .b  (rf_b),
    .y  (alu_y)
  );

  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Command fields and result. LDI's immediate goes straight into res_q so
  // WB always drives res_q; CLR reports rd=0 / result=0.
  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      op_q  <= '0;
      rd_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      res_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= cmd_op;
        rs1_q <= cmd_rs1;
        rs2_q <= cmd_rs2;
        rd_q  <= (cmd_op == OP_CLR) ? '0 : cmd_rd;
        res_q <= (cmd_op == OP_LDI) ? cmd_imm : '0;
      end
      if (state == S_EXEC) res_q <= alu_y;
    end
  end

  assign resp_result = res_q;
  assign resp_rd     = rd_q;

  always_comb begin
    state_nx   = state;
    cmd_ready  = 1'b0;
    rf_load    = 1'b0;
    rf_clear_n = 1'b1;
    rf_aaddr   = '0;
    rf_baddr   = '0;
    rf_caddr   = '0;
    rf_c       = '0;
    resp_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        cmd_ready = ~Clear;
        if (accept) begin
          if (cmd_op == OP_CLR)      state_nx = S_CLR;
          else if (cmd_op == OP_LDI) state_nx = S_WB;
          else                       state_nx = S_FETCH;
        end
      end
      // The Load edge that captures A/B also writes 0 into the scratch
      // register; the regfile always writes C on a Load edge.
      S_FETCH: begin
        rf_load  = 1'b1;
        rf_aaddr = rs1_q;
        rf_baddr = rs2_q;
        rf_caddr = SCRATCH_ADDR;
        state_nx = S_EXEC;
      end
      S_EXEC: state_nx = S_WB;
      S_WB: begin
        rf_load  = 1'b1;
        rf_caddr = rd_q;
        rf_c     = res_q;
        state_nx = S_DONE;
      end
      S_CLR: begin
        rf_clear_n = 1'b0;
        state_nx   = S_DONE;
      end
      S_DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer with a behavioural 16x16 register file and a
// command-level reference model of register contents.
module tb_regfile_sequencer;

  logic        Clk = 1'b0;
  logic        Clear = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0, cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic [15:0] cmd_imm = '0;
  logic [3:0]  rf_aaddr, rf_baddr, rf_caddr;
  logic [15:0] rf_c;
  logic        rf_load, rf_clear_n;
  logic [15:0] rf_a, rf_b;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [15:0] resp_result;
  logic [3:0]  resp_rd;

  int n_checks = 0;
  int n_pass   = 0;
  int overlap_cnt = 0;
  int clr_low_cnt = 0;

  logic [15:0] mem    [16];   // regfile model driven by the DUT pins
  logic [15:0] ref_rf [16];   // expected architectural contents

  always #5 Clk = ~Clk;

  regfile_sequencer dut (
    .Clk(Clk), .Clear(Clear),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .rf_aaddr(rf_aaddr), .rf_baddr(rf_baddr), .rf_caddr(rf_caddr), .rf_c(rf_c),
    .rf_load(rf_load), .rf_clear_n(rf_clear_n), .rf_a(rf_a), .rf_b(rf_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_rd(resp_rd)
  );

  // Register file: synchronous clear, read-old/write-new on Load.
  always @(posedge Clk) begin
    if (rf_clear_n === 1'b0) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (rf_load === 1'b1) begin
      rf_a <= mem[rf_aaddr];
      rf_b <= mem[rf_baddr];
      mem[rf_caddr] <= rf_c;
    end
  end

  always @(negedge Clk) begin
    if (rf_load === 1'b1 && rf_clear_n === 1'b0) overlap_cnt++;
    if (rf_clear_n === 1'b0) clr_low_cnt++;
  end

  function automatic logic [15:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int sh;
    sh = int'(b) % 16;
    case (op)
      4'd0: return 16'(a + b);
      4'd1: return 16'(a - b);
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << sh;
      4'd6: return a >> sh;
      default: return a;
    endcase
  endfunction

  task automatic ref_apply(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                           input logic [3:0] rs2, input logic [15:0] imm,
                           output logic [15:0] e_res, output logic [3:0] e_rd, output int e_lat);
    logic [15:0] a, b;
    if (op == 4'd9) begin
      for (int i = 0; i < 16; i++) ref_rf[i] = '0;
      e_res = '0; e_rd = '0; e_lat = 2;
    end else if (op == 4'd8) begin
      ref_rf[rd] = imm; e_res = imm; e_rd = rd; e_lat = 2;
    end else begin
      a = ref_rf[rs1]; b = ref_rf[rs2];
      ref_rf[15] = '0;                  // fetch zeroes the scratch register
      e_res = alu_ref(op, a, b);
      ref_rf[rd] = e_res; e_rd = rd; e_lat = 4;
    end
  endtask

  function automatic int mem_diff();
    int bad = 0;
    for (int i = 0; i < 16; i++) if (mem[i] !== ref_rf[i]) bad++;
    return bad;
  endfunction

  // Issue one command, wait for its response, hold resp_ready low 'hold' cycles.
  task automatic run_cmd(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                         input logic [3:0] rs2, input logic [15:0] imm, input int hold,
                         output logic [15:0] res, output logic [3:0] rdo, output int lat);
    int n = 0;
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 50) begin @(posedge Clk); #1; n++; end
    @(posedge Clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin @(posedge Clk); #1; lat++; end
    res = resp_result; rdo = resp_rd;
    repeat (hold) begin @(posedge Clk); #1; end
    resp_ready = 1'b1;
    @(posedge Clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 Clear = 1'b1;
    #1;
    n_checks++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready); else n_pass++;
    n_checks++;
    if ({rf_load, rf_clear_n, resp_valid} !== 3'b010)
      $display("FAIL reset_ctrl load/clear_n/resp_valid got=%b exp=010", {rf_load, rf_clear_n, resp_valid});
    else n_pass++;
    n_checks++;
    if ({rf_aaddr, rf_baddr, rf_caddr, rf_c} !== 28'h0)
      $display("FAIL reset_rf_bus got=%h exp=0", {rf_aaddr, rf_baddr, rf_caddr, rf_c});
    else n_pass++;
    n_checks++;
    if ({resp_result, resp_rd} !== 20'h0) $display("FAIL reset_resp got=%h exp=0", {resp_result, resp_rd});
    else n_pass++;
    repeat (3) @(posedge Clk);
    #1 Clear = 1'b0;
    #1;
    n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready got=%b exp=1", cmd_ready); else n_pass++;
  endtask

  task automatic test_clr();
    logic [15:0] r, er; logic [3:0] d, ed; int lat, el, c0;
    c0 = clr_low_cnt;
    run_cmd(4'd9, 4'd7, 4'd3, 4'd4, 16'h0, 0, r, d, lat);
    ref_apply(4'd9, 4'd7, 4'd3, 4'd4, 16'h0, er, ed, el);
    n_checks++; if (clr_low_cnt - c0 != 1) $display("FAIL clr_low_cycles got=%0d exp=1", clr_low_cnt - c0); else n_pass++;
    n_checks++; if (lat != 2) $display("FAIL clr_latency got=%0d exp=2", lat); else n_pass++;
    n_checks++; if (r !== 16'h0 || d !== 4'h0) $display("FAIL clr_resp got=%h/%h exp=0/0", r, d); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (mem[i] !== 16'h0) $display("FAIL clr_reg%0d got=%h exp=0", i, mem[i]); else n_pass++;
    end
  endtask

  task automatic test_alu_directed();
    // {op, rd, rs1, rs2, imm, expected result}
    logic [47:0] tbl [18];
    logic [47:0] t;
    logic [15:0] r, er; logic [3:0] d, ed; int lat, el;
    tbl = '{48'h8100_00FF_00FF, 48'h8200_0F0F_0F0F, 48'h0312_0000_100E, 48'h1421_0000_0E10,
            48'h8100_0000_0000, 48'h8200_0001_0001, 48'h1412_0000_FFFF, 48'h8100_00FF_00FF,
            48'h8200_0F0F_0F0F, 48'h8600_0014_0014, 48'h5516_0000_0FF0, 48'h6726_0000_00F0,
            48'h2812_0000_000F, 48'h3912_0000_0FFF, 48'h4A12_0000_0FF0, 48'h7B20_0000_0F0F,
            48'hCC10_0000_00FF, 48'h0112_0000_100E};
    for (int i = 0; i < 18; i++) begin
      t = tbl[i];
      run_cmd(t[47:44], t[43:40], t[39:36], t[35:32], t[31:16], 0, r, d, lat);
      ref_apply(t[47:44], t[43:40], t[39:36], t[35:32], t[31:16], er, ed, el);
      n_checks++; if (r !== t[15:0]) $display("FAIL alu_result[%0d] op=%0d got=%h exp=%h", i, t[47:44], r, t[15:0]); else n_pass++;
      n_checks++; if (d !== t[43:40]) $display("FAIL alu_rd[%0d] got=%h exp=%h", i, d, t[43:40]); else n_pass++;
      n_checks++; if (lat != el) $display("FAIL alu_latency[%0d] op=%0d got=%0d exp=%0d", i, t[47:44], lat, el); else n_pass++;
      n_checks++; if (mem_diff() != 0) $display("FAIL alu_regs[%0d] mismatching=%0d exp=0", i, mem_diff()); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] er; logic [3:0] ed; int el, n;
    cmd_op = 4'd8; cmd_rd = 4'd9; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = 16'hA5A5; cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(posedge Clk); #1; n++; end
    @(posedge Clk); #1;
    // Next command presented immediately and held.
    cmd_op = 4'd0; cmd_rd = 4'd10; cmd_rs1 = 4'd9; cmd_rs2 = 4'd9;
    n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin @(posedge Clk); #1; n++; end
    n_checks++; if (resp_result !== 16'hA5A5) $display("FAIL bp_first_result got=%h exp=a5a5", resp_result); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      n_checks++;
      if (resp_valid !== 1'b1 || resp_result !== 16'hA5A5 || resp_rd !== 4'd9 || cmd_ready !== 1'b0)
        $display("FAIL bp_hold[%0d] valid/result/rd/ready got=%b/%h/%h/%b exp=1/a5a5/9/0",
                 i, resp_valid, resp_result, resp_rd, cmd_ready);
      else n_pass++;
    end
    resp_ready = 1'b1;
    @(posedge Clk); #1;
    resp_ready = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL bp_idle_gap valid/ready got=%b/%b exp=0/1", resp_valid, cmd_ready);
    else n_pass++;
    @(posedge Clk); #1;
    cmd_valid = 1'b0;
    n_checks++; if (cmd_ready !== 1'b0) $display("FAIL bp_second_accept ready got=%b exp=0", cmd_ready); else n_pass++;
    n = 1;
    while (resp_valid !== 1'b1 && n < 20) begin @(posedge Clk); #1; n++; end
    ref_apply(4'd8, 4'd9, 4'd0, 4'd0, 16'hA5A5, er, ed, el);
    ref_apply(4'd0, 4'd10, 4'd9, 4'd9, 16'h0, er, ed, el);
    n_checks++; if (n != 4) $display("FAIL bp_second_latency got=%0d exp=4", n); else n_pass++;
    n_checks++; if (resp_result !== 16'h4B4A || resp_rd !== 4'd10)
      $display("FAIL bp_second_resp got=%h/%h exp=4b4a/a", resp_result, resp_rd); else n_pass++;
    resp_ready = 1'b1;
    @(posedge Clk); #1;
    resp_ready = 1'b0;
    n_checks++; if (mem_diff() != 0) $display("FAIL bp_regs mismatching=%0d exp=0", mem_diff()); else n_pass++;
  endtask

  task automatic test_clear_abort();
    logic [15:0] r, er; logic [3:0] d, ed; int lat, el, n, seen;
    for (int k = 0; k < 2; k++) begin
      // k=0: ALU op cut in FETCH; k=1: LDI cut in WB
      cmd_op = (k == 0) ? 4'd0 : 4'd8; cmd_rd = 4'd5; cmd_rs1 = 4'd1; cmd_rs2 = 4'd2;
      cmd_imm = 16'h1234; cmd_valid = 1'b1;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin @(posedge Clk); #1; n++; end
      @(posedge Clk); #1;
      cmd_valid = 1'b0;
      n_checks++; if (rf_load !== 1'b1) $display("FAIL abort%0d_pre_load got=%b exp=1", k, rf_load); else n_pass++;
      Clear = 1'b1;
      #1;
      n_checks++;
      if ({rf_load, rf_clear_n, resp_valid, cmd_ready} !== 4'b0100 ||
          {rf_aaddr, rf_baddr, rf_caddr, rf_c} !== 28'h0 || {resp_result, resp_rd} !== 20'h0)
        $display("FAIL abort%0d_async ctrl=%b bus=%h resp=%h exp=0100/0/0", k,
                 {rf_load, rf_clear_n, resp_valid, cmd_ready}, {rf_aaddr, rf_baddr, rf_caddr, rf_c},
                 {resp_result, resp_rd});
      else n_pass++;
      @(posedge Clk); #1;
      Clear = 1'b0;
      #1;
      n_checks++; if (cmd_ready !== 1'b1) $display("FAIL abort%0d_ready got=%b exp=1", k, cmd_ready); else n_pass++;
      seen = 0;
      repeat (6) begin @(posedge Clk); #1; if (resp_valid === 1'b1) seen++; end
      n_checks++; if (seen != 0) $display("FAIL abort%0d_no_resp got=%0d exp=0", k, seen); else n_pass++;
      n_checks++; if (mem_diff() != 0) $display("FAIL abort%0d_regs mismatching=%0d exp=0", k, mem_diff()); else n_pass++;
    end
    run_cmd(4'd8, 4'd5, 4'd0, 4'd0, 16'h4321, 1, r, d, lat);
    ref_apply(4'd8, 4'd5, 4'd0, 4'd0, 16'h4321, er, ed, el);
    n_checks++;
    if (r !== 16'h4321 || d !== 4'd5 || lat != 2)
      $display("FAIL abort_recover result/rd/lat got=%h/%h/%0d exp=4321/5/2", r, d, lat);
    else n_pass++;
    n_checks++; if (mem[5] !== 16'h4321) $display("FAIL abort_recover_reg got=%h exp=4321", mem[5]); else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] r, er, imm; logic [3:0] d, ed, op, rd, rs1, rs2; int lat, el, sel;
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 19);
      op  = (sel >= 19) ? 4'd9 : (sel >= 16) ? 4'd8 : 4'(sel);
      rd  = 4'($urandom_range(0, 15));
      rs1 = 4'($urandom_range(0, 14));
      rs2 = 4'($urandom_range(0, 14));
      imm = 16'($urandom);
      run_cmd(op, rd, rs1, rs2, imm, $urandom_range(0, 3), r, d, lat);
      ref_apply(op, rd, rs1, rs2, imm, er, ed, el);
      n_checks++;
      if (r !== er || d !== ed || lat != el)
        $display("FAIL rand[%0d] op=%0d result/rd/lat got=%h/%h/%0d exp=%h/%h/%0d", i, op, r, d, lat, er, ed, el);
      else n_pass++;
      n_checks++; if (mem_diff() != 0) $display("FAIL rand_regs[%0d] mismatching=%0d exp=0", i, mem_diff()); else n_pass++;
    end
    n_checks++; if (overlap_cnt != 0) $display("FAIL load_clear_overlap got=%0d exp=0", overlap_cnt); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_rf[i] = '0;
    test_reset();
    test_clr();
    test_alu_directed();
    test_back_to_back();
    test_clear_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
